// File: rtl/d_input_debounce_if.sv
// ============================================================================
// d_input_debounce_if : raw level / qualify tick in, debounced level out
// Rev 1.0
// ============================================================================
`default_nettype none

interface d_input_debounce_if;
  logic i_din_async;
  logic i_en;
  logic o_d_out;
  logic o_rise;
  logic o_fall;
  logic o_busy;

  modport master (
    output i_din_async,
    output i_en,
    input  o_d_out,
    input  o_rise,
    input  o_fall,
    input  o_busy
  );

  modport slave (
    input  i_din_async,
    input  i_en,
    output o_d_out,
    output o_rise,
    output o_fall,
    output o_busy
  );
endinterface

`default_nettype wire

// File: rtl/d_input_debounce.sv
// ============================================================================
// d_input_debounce : synchronise and debounce the flip-flop D input level
// Rev 1.0
// ============================================================================
`default_nettype none

module d_input_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                clk,
  input  logic                rst,
  d_input_debounce_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_d_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_d_out_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_s;

  // Raw input lands directly in the first flop; nothing precedes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_din_async};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_d_out <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_out <= w_d_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // A reversal of s is tested before the count, so an abort always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_out_nxt = r_d_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_CHK_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (bus.i_en) begin
          if (r_cnt == C_CNT_LAST) begin
            w_state_nxt = ST_HIGH;
            w_d_out_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_CHK_LOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHK_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (bus.i_en) begin
          if (r_cnt == C_CNT_LAST) begin
            w_state_nxt = ST_LOW;
            w_d_out_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.o_d_out = r_d_out;
  assign bus.o_rise  = r_rise;
  assign bus.o_fall  = r_fall;
  assign bus.o_busy  = (r_state == ST_CHK_HIGH) || (r_state == ST_CHK_LOW);

endmodule

`default_nettype wire

// File: tb/tb_d_input_debounce.sv
// ============================================================================
// tb_d_input_debounce : directed stimulus, strobe scoreboard, level checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_d_input_debounce;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    bit is_rise;
    int at;
  } ev_t;

  ev_t exp_q[$];

  d_input_debounce_if bus ();

  d_input_debounce #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_rise, input int at);
    ev_t e;
    e.is_rise = is_rise;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the next scheduled event exactly.
  always @(negedge clk) begin
    if (bus.o_rise || bus.o_fall) begin
      chk("rise_fall_exclusive", int'(bus.o_rise && bus.o_fall), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_rise", int'(bus.o_rise), 0);
        chk("unexpected_strobe_fall", int'(bus.o_fall), 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_kind_rise", int'(bus.o_rise), int'(e.is_rise));
        chk("strobe_cycle", cyc, e.at);
        chk("strobe_level", int'(bus.o_d_out), int'(e.is_rise));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    cyc             = 0;
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    bus.i_din_async = 1'b1;
    bus.i_en        = 1'b1;

    // T1: reset held two edges with input high
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("t1_d_out", int'(bus.o_d_out), 0);
      chk("t1_rise",  int'(bus.o_rise), 0);
      chk("t1_fall",  int'(bus.o_fall), 0);
      chk("t1_busy",  int'(bus.o_busy), 0);
    end
    bus.i_din_async = 1'b0;
    rst             = 1'b1;
    repeat (4) @(negedge clk);

    // T3: high for 3 edges only -> glitch rejected
    bus.i_din_async = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) bus.i_din_async = 1'b0;
      if (k == 5) chk("t3_busy_mid", int'(bus.o_busy), 1);
      if (k == 7) chk("t3_busy_end", int'(bus.o_busy), 0);
      if (k == 8) chk("t3_d_out", int'(bus.o_d_out), 0);
    end

    // T2: clean rise, strobe at edge 7
    c = cyc;
    bus.i_din_async = 1'b1;
    push(1'b1, c + 7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 2) chk("t2_busy_pre", int'(bus.o_busy), 0);
      if (k >= 4 && k <= 6) chk("t2_busy_qual", int'(bus.o_busy), 1);
      if (k == 6) chk("t2_d_out_pre", int'(bus.o_d_out), 0);
      if (k == 7) chk("t2_busy_post", int'(bus.o_busy), 0);
      if (k == 7) chk("t2_d_out", int'(bus.o_d_out), 1);
    end
    chk("t2_events_done", exp_q.size(), 0);

    // T4: clean fall at edge 7, then a 2-edge bounce high is ignored
    c = cyc;
    bus.i_din_async = 1'b0;
    push(1'b0, c + 7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) chk("t4_d_out_pre", int'(bus.o_d_out), 1);
      if (k == 7) chk("t4_d_out", int'(bus.o_d_out), 0);
    end
    chk("t4_events_done", exp_q.size(), 0);
    bus.i_din_async = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) bus.i_din_async = 1'b0;
      if (k == 4) chk("t4_bounce_busy", int'(bus.o_busy), 1);
      if (k == 6) chk("t4_bounce_idle", int'(bus.o_busy), 0);
    end
    chk("t4_bounce_d_out", int'(bus.o_d_out), 0);

    // T5: en high only on even edges -> counts at 4,6,8, qualifies at 10
    c = cyc;
    bus.i_din_async = 1'b1;
    push(1'b1, c + 10);
    for (int k = 1; k <= 12; k++) begin
      bus.i_en = (k % 2 == 0);
      @(negedge clk);
      if (k == 9) chk("t5_busy_hold", int'(bus.o_busy), 1);
      if (k == 9) chk("t5_d_out_pre", int'(bus.o_d_out), 0);
      if (k == 10) chk("t5_d_out", int'(bus.o_d_out), 1);
    end
    bus.i_en = 1'b1;
    chk("t5_events_done", exp_q.size(), 0);

    // T7: reset while HIGH drops d_out without a fall strobe, then re-qualifies
    rst = 1'b0;
    @(negedge clk);
    chk("t7_d_out_rst", int'(bus.o_d_out), 0);
    chk("t7_busy_rst", int'(bus.o_busy), 0);
    rst = 1'b1;
    c = cyc;
    push(1'b1, c + 7);
    repeat (9) @(negedge clk);
    chk("t7_d_out", int'(bus.o_d_out), 1);
    chk("t7_events_done", exp_q.size(), 0);

    c = cyc;
    bus.i_din_async = 1'b0;
    push(1'b0, c + 7);
    repeat (9) @(negedge clk);
    chk("t7_fall_done", exp_q.size(), 0);

    // T6: reset at cnt=2 in CHK_HIGH, release with input high
    bus.i_din_async = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_busy_mid", int'(bus.o_busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_d_out_rst", int'(bus.o_d_out), 0);
    chk("t6_busy_rst", int'(bus.o_busy), 0);
    rst = 1'b1;
    c = cyc;
    push(1'b1, c + 7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) chk("t6_d_out_pre", int'(bus.o_d_out), 0);
      if (k == 7) chk("t6_d_out", int'(bus.o_d_out), 1);
    end
    chk("t6_events_done", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
